mem_stage: RTL and testbench

- Memory stage of the 5-stage LoongArch pipeline; sits between the execute stage and write-back.
- Latches one instruction from execute and waits for the data-SRAM response of the request issued by execute.
- Extracts and extends load data, buffers a response that arrives while write-back stalls, and forwards results and exception state.
- Drops responses that belong to flushed instructions.

---
 rtl/pipe_pkg.sv | 19 +
 rtl/load_extend.sv | 44 ++++
 rtl/mem_stage.sv | 221 ++++++++++++++++++++++
 tb/tb_mem_stage.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: load-op bit positions, execute-to-memory
// field widths and the default data-path width.
package pipe_pkg;

    localparam int DATA_W_DEF = 32;

    // Execute-to-memory field widths
    localparam int PC_W    = 32;
    localparam int DEST_W  = 5;
    localparam int LD_OP_W = 5;

    // Bit positions inside ld_op = {ld_b, ld_bu, ld_h, ld_hu, ld_w}
    localparam int LD_B  = 4;
    localparam int LD_BU = 3;
    localparam int LD_H  = 2;
    localparam int LD_HU = 1;
    localparam int LD_W  = 0;

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extraction: selects the byte/halfword addressed
// by addr_i inside rdata_i and sign- or zero-extends it to DATA_W bits.
module load_extend
    import pipe_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [LD_OP_W-1:0] ld_op_i,
    input  logic [1:0]         addr_i,
    input  logic [DATA_W-1:0]  rdata_i,
    output logic [DATA_W-1:0]  result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Pick the addressed byte and halfword lanes out of the word
    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    // Extend the selected lane according to the one-hot load type
    always_comb begin
        result_o = '0;
        if (ld_op_i[LD_B]) begin
            result_o = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
        end else if (ld_op_i[LD_BU]) begin
            result_o = {{(DATA_W-8){1'b0}}, byte_sel};
        end else if (ld_op_i[LD_H]) begin
            result_o = {{(DATA_W-16){half_sel[15]}}, half_sel};
        end else if (ld_op_i[LD_HU]) begin
            result_o = {{(DATA_W-16){1'b0}}, half_sel};
        end else if (ld_op_i[LD_W]) begin
            result_o = rdata_i;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 5-stage pipeline. Holds one instruction from execute,
// waits for the data-SRAM response of any request execute issued, buffers a
// response that arrives while write-back stalls, and discards responses that
// belong to flushed instructions (tracked by drop_cnt).
// Optional: define MS_STALL_CNT_EN to add the ms_stall_cnt output.
//
// Handshake: an instruction moves from execute into this stage on a clock
// edge where es_to_ms_valid & ms_allowin, and leaves to write-back on an edge
// where ms_to_ws_valid & ws_allowin. valid never depends on the consumer's
// allowin except through the shared flush.
module mem_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int DROP_CNT_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                es_to_ms_valid,
    output logic                ms_allowin,
    input  logic [PC_W-1:0]     es_pc,
    input  logic [DATA_W-1:0]   es_result,
    input  logic [DEST_W-1:0]   es_dest,
    input  logic                es_gr_we,
    input  logic                es_res_from_mem,
    input  logic [LD_OP_W-1:0]  es_ld_op,
    input  logic                es_req_sent,
    input  logic                es_ex,
    input  logic                es_ertn,
    input  logic                es_refetch,
    input  logic                data_sram_data_ok,
    input  logic [DATA_W-1:0]   data_sram_rdata,
    input  logic                ws_allowin,
    input  logic                wb_flush,
    output logic                ms_to_ws_valid,
    output logic [PC_W-1:0]     ms_pc,
    output logic [DATA_W-1:0]   ms_final_result,
    output logic [DEST_W-1:0]   ms_dest,
    output logic                ms_gr_we,
    output logic                ms_ex_out,
    output logic                ms_ertn_out,
    output logic                ms_refetch_out,
`ifdef MS_STALL_CNT_EN
    output logic [31:0]         ms_stall_cnt,
`endif
    output logic                ms_fwd_busy
);

    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    // Instruction state
    logic                ms_valid_q,   ms_valid_d;
    logic [PC_W-1:0]     pc_q,         pc_d;
    logic [DATA_W-1:0]   result_q,     result_d;
    logic [DEST_W-1:0]   dest_q,       dest_d;
    logic                gr_we_q,      gr_we_d;
    logic                from_mem_q,   from_mem_d;
    logic [LD_OP_W-1:0]  ld_op_q,      ld_op_d;
    logic                req_r_q,      req_r_d;
    logic                ex_q,         ex_d;
    logic                ertn_q,       ertn_d;
    logic                refetch_q,    refetch_d;

    // Response buffer and orphan-response counter
    logic                buf_valid_q,  buf_valid_d;
    logic [DATA_W-1:0]   buf_data_q,   buf_data_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic                drop_zero;
    logic                ms_ready_go;
    logic                ms_capture;
    logic                ms_leave;
    logic                rsp_accept;
    logic                drop_inc;
    logic                drop_dec;
    logic [DATA_W-1:0]   rdata_sel;
    logic [DATA_W-1:0]   ld_data;

    assign drop_zero   = (drop_cnt_q == '0);
    assign ms_ready_go = ~req_r_q | buf_valid_q | (data_sram_data_ok & drop_zero);
    assign ms_allowin  = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go & ~wb_flush;
    assign ms_leave    = ms_to_ws_valid & ws_allowin;
    assign ms_capture  = es_to_ms_valid & ms_allowin;

    // A response belongs to the resident instruction only when no orphans are pending
    assign rsp_accept  = data_sram_data_ok & drop_zero & ms_valid_q & req_r_q & ~buf_valid_q;
    assign drop_dec    = data_sram_data_ok & ~drop_zero;
    // A flushed instruction leaves an orphan unless its response was already
    // buffered or is being consumed in this very cycle.
    assign drop_inc    = wb_flush & ms_valid_q & req_r_q & ~buf_valid_q
                         & ~(data_sram_data_ok & drop_zero);

    // Next-state for the resident instruction, buffer and discard counter
    always_comb begin
        ms_valid_d  = ms_valid_q;
        pc_d        = pc_q;
        result_d    = result_q;
        dest_d      = dest_q;
        gr_we_d     = gr_we_q;
        from_mem_d  = from_mem_q;
        ld_op_d     = ld_op_q;
        req_r_d     = req_r_q;
        ex_d        = ex_q;
        ertn_d      = ertn_q;
        refetch_d   = refetch_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        drop_cnt_d  = drop_cnt_q;

        if (wb_flush) begin
            ms_valid_d = 1'b0;
        end else if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end

        if (ms_capture) begin
            pc_d       = es_pc;
            result_d   = es_result;
            dest_d     = es_dest;
            gr_we_d    = es_gr_we;
            from_mem_d = es_res_from_mem;
            ld_op_d    = es_ld_op;
            req_r_d    = es_req_sent;
            ex_d       = es_ex;
            ertn_d     = es_ertn;
            refetch_d  = es_refetch;
        end

        if (wb_flush || ms_leave) begin
            buf_valid_d = 1'b0;
        end else if (rsp_accept) begin
            buf_valid_d = 1'b1;
            buf_data_d  = data_sram_rdata;
        end

        case ({drop_inc, drop_dec})
            2'b10:   drop_cnt_d = (drop_cnt_q == DROP_MAX) ? DROP_MAX : drop_cnt_q + 1'b1;
            2'b01:   drop_cnt_d = drop_cnt_q - 1'b1;
            default: drop_cnt_d = drop_cnt_q;
        endcase
    end

    // Stage registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ms_valid_q  <= 1'b0;
            pc_q        <= '0;
            result_q    <= '0;
            dest_q      <= '0;
            gr_we_q     <= 1'b0;
            from_mem_q  <= 1'b0;
            ld_op_q     <= '0;
            req_r_q     <= 1'b0;
            ex_q        <= 1'b0;
            ertn_q      <= 1'b0;
            refetch_q   <= 1'b0;
            buf_valid_q <= 1'b0;
            buf_data_q  <= '0;
            drop_cnt_q  <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            pc_q        <= pc_d;
            result_q    <= result_d;
            dest_q      <= dest_d;
            gr_we_q     <= gr_we_d;
            from_mem_q  <= from_mem_d;
            ld_op_q     <= ld_op_d;
            req_r_q     <= req_r_d;
            ex_q        <= ex_d;
            ertn_q      <= ertn_d;
            refetch_q   <= refetch_d;
            buf_valid_q <= buf_valid_d;
            buf_data_q  <= buf_data_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Buffered data takes precedence over the live SRAM bus
    assign rdata_sel = buf_valid_q ? buf_data_q : data_sram_rdata;

    load_extend #(
        .DATA_W (DATA_W)
    ) u_load_extend (
        .ld_op_i  (ld_op_q),
        .addr_i   (result_q[1:0]),
        .rdata_i  (rdata_sel),
        .result_o (ld_data)
    );

    assign ms_pc           = pc_q;
    assign ms_dest         = dest_q;
    assign ms_final_result = from_mem_q ? ld_data : result_q;
    assign ms_gr_we        = ms_valid_q & gr_we_q;
    assign ms_ex_out       = ms_valid_q & ex_q;
    assign ms_ertn_out     = ms_valid_q & ertn_q;
    assign ms_refetch_out  = ms_valid_q & refetch_q;
    assign ms_fwd_busy     = ms_valid_q & from_mem_q & ~ms_ready_go;

`ifdef MS_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    // Count cycles a valid instruction sits waiting for its response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else if (ms_valid_q && !ms_ready_go) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign ms_stall_cnt = stall_cnt_q;
`endif

    // More orphan responses than the counter can track is a protocol error
    drop_cnt_overflow_a: assert property (
        @(posedge clk) disable iff (reset)
        !(drop_inc && !drop_dec && drop_cnt_q == DROP_MAX)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load-extraction cases, response
// buffering under write-back stall, flush/discard, exception and reset cases,
// plus a short randomized load run. Results leaving the stage are matched
// against a scoreboard filled when each instruction is driven.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic        es_to_ms_valid;
  logic        ms_allowin;
  logic [31:0] es_pc;
  logic [31:0] es_result;
  logic [4:0]  es_dest;
  logic        es_gr_we;
  logic        es_res_from_mem;
  logic [4:0]  es_ld_op;
  logic        es_req_sent;
  logic        es_ex;
  logic        es_ertn;
  logic        es_refetch;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        ws_allowin;
  logic        wb_flush;
  logic        ms_to_ws_valid;
  logic [31:0] ms_pc;
  logic [31:0] ms_final_result;
  logic [4:0]  ms_dest;
  logic        ms_gr_we;
  logic        ms_ex_out;
  logic        ms_ertn_out;
  logic        ms_refetch_out;
  logic        ms_fwd_busy;
`ifdef MS_STALL_CNT_EN
  logic [31:0] ms_stall_cnt;
`endif

  localparam logic [4:0] OP_B  = 5'b10000;
  localparam logic [4:0] OP_BU = 5'b01000;
  localparam logic [4:0] OP_H  = 5'b00100;
  localparam logic [4:0] OP_HU = 5'b00010;
  localparam logic [4:0] OP_W  = 5'b00001;

  int tests_run;
  int tests_failed;

  logic [31:0] exp_q[$];
  logic [31:0] exp_pc_q[$];
  bit          care_q[$];

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .es_to_ms_valid    (es_to_ms_valid),
    .ms_allowin        (ms_allowin),
    .es_pc             (es_pc),
    .es_result         (es_result),
    .es_dest           (es_dest),
    .es_gr_we          (es_gr_we),
    .es_res_from_mem   (es_res_from_mem),
    .es_ld_op          (es_ld_op),
    .es_req_sent       (es_req_sent),
    .es_ex             (es_ex),
    .es_ertn           (es_ertn),
    .es_refetch        (es_refetch),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata),
    .ws_allowin        (ws_allowin),
    .wb_flush          (wb_flush),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_pc             (ms_pc),
    .ms_final_result   (ms_final_result),
    .ms_dest           (ms_dest),
    .ms_gr_we          (ms_gr_we),
    .ms_ex_out         (ms_ex_out),
    .ms_ertn_out       (ms_ertn_out),
    .ms_refetch_out    (ms_refetch_out),
`ifdef MS_STALL_CNT_EN
    .ms_stall_cnt      (ms_stall_cnt),
`endif
    .ms_fwd_busy       (ms_fwd_busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference load extraction, written as shift-and-mask
  function automatic logic [31:0] model_load(input logic [4:0] op, input logic [1:0] a,
                                             input logic [31:0] d);
    logic [31:0] sb;
    logic [31:0] sh;
    sb = d >> (int'(a) * 8);
    sh = d >> (int'(a[1]) * 16);
    case (op)
      OP_B:    return {{24{sb[7]}}, sb[7:0]};
      OP_BU:   return sb & 32'h0000_00ff;
      OP_H:    return {{16{sh[15]}}, sh[15:0]};
      OP_HU:   return sh & 32'h0000_ffff;
      default: return d;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e_res;
        logic [31:0] e_pc;
        bit          e_care;
        e_res  = exp_q.pop_front();
        e_pc   = exp_pc_q.pop_front();
        e_care = care_q.pop_front();
        check("out_pc", ms_pc, e_pc);
        if (e_care) check("out_result", ms_final_result, e_res);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_es(input logic [31:0] pc, input logic [31:0] res, input logic from_mem,
                          input logic [4:0] op, input logic ex, input logic ertn,
                          input logic refetch, input logic [31:0] exp_res,
                          input bit care, input bit push);
    for (int i = 0; i < 20 && !ms_allowin; i++) tick();
    if (!ms_allowin) check("allowin_timeout", 32'(ms_allowin), 32'd1);
    es_pc           = pc;
    es_result       = res;
    es_dest         = pc[6:2];
    es_gr_we        = 1'b1;
    es_res_from_mem = from_mem;
    es_ld_op        = op;
    es_req_sent     = from_mem;
    es_ex           = ex;
    es_ertn         = ertn;
    es_refetch      = refetch;
    es_to_ms_valid  = 1'b1;
    if (push) begin
      exp_q.push_back(exp_res);
      exp_pc_q.push_back(pc);
      care_q.push_back(care);
    end
    tick();
    es_to_ms_valid = 1'b0;
  endtask

  task automatic respond(input logic [31:0] data);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = data;
    tick();
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom();
  endtask

  task automatic do_load(input logic [31:0] pc, input logic [4:0] op, input logic [31:0] addr,
                         input logic [31:0] data, input int delay);
    drive_es(pc, addr, 1'b1, op, 1'b0, 1'b0, 1'b0, model_load(op, addr[1:0], data), 1'b1, 1'b1);
    repeat (delay) tick();
    respond(data);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    tests_run         = 0;
    tests_failed      = 0;
    reset             = 1'b1;
    es_to_ms_valid    = 1'b0;
    es_pc             = '0;
    es_result         = '0;
    es_dest           = '0;
    es_gr_we          = 1'b0;
    es_res_from_mem   = 1'b0;
    es_ld_op          = '0;
    es_req_sent       = 1'b0;
    es_ex             = 1'b0;
    es_ertn           = 1'b0;
    es_refetch        = 1'b0;
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = '0;
    ws_allowin        = 1'b1;
    wb_flush          = 1'b0;

    // Reset state
    #2;
    check("rst_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    check("rst_allowin",     32'(ms_allowin),     32'd1);
    check("rst_gr_we",       32'(ms_gr_we),       32'd0);
    check("rst_fwd_busy",    32'(ms_fwd_busy),    32'd0);
    check("rst_result",      ms_final_result,     32'd0);
    repeat (2) tick();
    reset = 1'b0;
    tick();

    // Non-memory add: valid the cycle after capture, never busy
    drive_es(32'h0000_0100, 32'h55, 1'b0, 5'b0, 1'b0, 1'b0, 1'b0, 32'h55, 1'b1, 1'b1);
    @(negedge clk);
    check("add_to_ws_valid", 32'(ms_to_ws_valid), 32'd1);
    check("add_fwd_busy",    32'(ms_fwd_busy),    32'd0);
    check("add_gr_we",       32'(ms_gr_we),       32'd1);
    tick();

    // Directed load extraction, data_ok in the cycle after capture
    do_load(32'h0000_0200, OP_B,  32'h1003, 32'h80FF_1234, 0);
    do_load(32'h0000_0204, OP_BU, 32'h1003, 32'h80FF_1234, 0);
    do_load(32'h0000_0208, OP_H,  32'h2002, 32'h8001_0000, 0);
    do_load(32'h0000_020c, OP_W,  32'h2000, 32'h8001_0000, 0);
    check("model_ld_b", model_load(OP_B, 2'd3, 32'h80FF_1234), 32'hFFFF_FF80);

    // Load waits: busy and not valid before data_ok
    drive_es(32'h0000_0210, 32'h3001, 1'b1, OP_BU, 1'b0, 1'b0, 1'b0,
             model_load(OP_BU, 2'd1, 32'h0000_A500), 1'b1, 1'b1);
    @(negedge clk);
    check("wait_fwd_busy",    32'(ms_fwd_busy),    32'd1);
    check("wait_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    tick();
    respond(32'h0000_A500);

    // Response arrives while write-back stalls: buffered, then released
    drive_es(32'h0000_0300, 32'h2002, 1'b1, OP_HU, 1'b0, 1'b0, 1'b0, 32'h0000_8001, 1'b1, 1'b1);
    ws_allowin = 1'b0;
    respond(32'h8001_0000);
    data_sram_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("buf_valid",       32'(dut.buf_valid_q), 32'd1);
      check("buf_to_ws_valid", 32'(ms_to_ws_valid),  32'd1);
      check("buf_allowin",     32'(ms_allowin),      32'd0);
      tick();
    end
    ws_allowin = 1'b1;
    @(negedge clk);
    check("buf_release_allowin", 32'(ms_allowin), 32'd1);
    tick();

    // Flush before data_ok: orphan response counted then discarded
    drive_es(32'h0000_0400, 32'h4000, 1'b1, OP_W, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("flush_pre_busy", 32'(ms_fwd_busy), 32'd1);
    tick();
    wb_flush = 1'b1;
    tick();
    wb_flush = 1'b0;
    @(negedge clk);
    check("flush_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    check("flush_allowin",     32'(ms_allowin),     32'd1);
    check("flush_drop_cnt",    32'(dut.drop_cnt_q), 32'd1);
    tick();
    drive_es(32'h0000_0404, 32'h4004, 1'b1, OP_W, 1'b0, 1'b0, 1'b0, 32'h1234, 1'b1, 1'b1);
    data_sram_data_ok = 1'b1;
    data_sram_rdata   = 32'h0000_DEAD;
    @(negedge clk);
    check("discard_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    tick();
    respond(32'h0000_1234);
    check("discard_drop_cnt", 32'(dut.drop_cnt_q), 32'd0);

    // Exception-carrying load: flag visible at once, still waits its response
    drive_es(32'h0000_0500, 32'h5000, 1'b1, OP_W, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    check("ex_out",          32'(ms_ex_out),      32'd1);
    check("ex_to_ws_valid",  32'(ms_to_ws_valid), 32'd0);
    tick();
    @(negedge clk);
    check("ex_still_waiting", 32'(ms_to_ws_valid), 32'd0);
    tick();
    respond($urandom());

    // ertn / refetch flags forwarded
    drive_es(32'h0000_0600, 32'h60, 1'b0, 5'b0, 1'b0, 1'b1, 1'b1, 32'h60, 1'b1, 1'b1);
    @(negedge clk);
    check("ertn_out",    32'(ms_ertn_out),    32'd1);
    check("refetch_out", 32'(ms_refetch_out), 32'd1);
    check("ertn_ex_out", 32'(ms_ex_out),      32'd0);
    tick();

    // Randomized loads with random response delay
    for (int n = 0; n < 10; n++) begin
      logic [4:0]  op;
      logic [31:0] addr;
      int          sel;
      sel  = $urandom_range(0, 4);
      op   = 5'b00001 << sel;
      addr = $urandom() & 32'hFFFF_FFFC;
      if (op == OP_B || op == OP_BU) addr[1:0] = 2'($urandom_range(0, 3));
      if (op == OP_H || op == OP_HU) addr[1]   = 1'($urandom_range(0, 1));
      do_load(32'h0000_1000 + 32'(n * 4), op, addr, $urandom(), $urandom_range(0, 3));
    end

    // Reset while a load waits: outputs drop in the same cycle
    drive_es(32'h0000_0700, 32'h7003, 1'b1, OP_B, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    check("mid_fwd_busy", 32'(ms_fwd_busy), 32'd1);
    tick();
    reset = 1'b1;
    #1;
    check("mid_rst_to_ws_valid", 32'(ms_to_ws_valid), 32'd0);
    check("mid_rst_fwd_busy",    32'(ms_fwd_busy),    32'd0);
    check("mid_rst_gr_we",       32'(ms_gr_we),       32'd0);
    check("mid_rst_ex",          32'(ms_ex_out),      32'd0);
    check("mid_rst_pc",          ms_pc,               32'd0);
    check("mid_rst_result",      ms_final_result,     32'd0);
    check("mid_rst_drop_cnt",    32'(dut.drop_cnt_q), 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("post_rst_allowin", 32'(ms_allowin), 32'd1);

    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
